// File: rtl/alarm_sched_if.sv
// Alarm sequencer bus: time/alarm inputs and control pulses into the
// sequencer, buzzer/snooze status back out.
//   master : drives i_* (clock counters, alarm regs, buttons), reads o_*
//   slave  : the sequencer itself
interface alarm_sched_if #(
   parameter int MAX_SNOOZE = 3
);
   localparam int CW = $clog2(MAX_SNOOZE + 1);

   logic          i_sec_tick;
   logic [4:0]    i_cur_hrs;
   logic [5:0]    i_cur_min;
   logic [2:0]    i_cur_day;
   logic [4:0]    i_alm_hrs;
   logic [5:0]    i_alm_min;
   logic          i_alarmon;
   logic          i_setmode;
   logic          i_snooze;
   logic          i_dismiss;
   logic          o_buzz;
   logic          o_snoozing;
   logic [CW-1:0] o_snooze_cnt;

   modport master (
      output i_sec_tick, i_cur_hrs, i_cur_min, i_cur_day, i_alm_hrs, i_alm_min,
             i_alarmon, i_setmode, i_snooze, i_dismiss,
      input  o_buzz, o_snoozing, o_snooze_cnt
   );

   modport slave (
      input  i_sec_tick, i_cur_hrs, i_cur_min, i_cur_day, i_alm_hrs, i_alm_min,
             i_alarmon, i_setmode, i_snooze, i_dismiss,
      output o_buzz, o_snoozing, o_snooze_cnt
   );
endinterface

// File: rtl/alarm_sched.sv
// Weekday alarm sequencer: day-gated alarm match, ring timeout, snooze with
// a retry limit, and dismiss. Owns the buzzer drive.
//   i_clk, i_rst : system clock, async active-high reset
//   bus (slave)  : sec tick, current time/day, alarm time, alarmon/setmode,
//                  snooze/dismiss pulses in; buzz, snoozing, snooze count out
module alarm_sched #(
   parameter int         RING_SECS   = 60,
   parameter int         SNOOZE_SECS = 300,
   parameter int         MAX_SNOOZE  = 3,
   parameter logic [6:0] DAY_MASK    = 7'b0011111
) (
   input  logic           i_clk,
   input  logic           i_rst,
   alarm_sched_if.slave   bus
);
   localparam int CW = $clog2(MAX_SNOOZE + 1);
   localparam int RW = $clog2(RING_SECS + 1);
   localparam int SW = $clog2(SNOOZE_SECS + 1);
   // Bit 7 padded to 0 so a bogus day value 7 never matches.
   localparam logic [7:0] MASK8 = {1'b0, DAY_MASK};

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

   state_t        r_state;
   logic [RW-1:0] r_ring;
   logic [SW-1:0] r_snz;
   logic [CW-1:0] r_cnt;
   logic          r_buzz;
   logic          r_snoozing;
   logic          r_match_q;

   logic w_match;
   logic w_trig;
   logic w_off;

   assign w_match = bus.i_alarmon & ~bus.i_setmode & MASK8[bus.i_cur_day] &
                    (bus.i_cur_hrs == bus.i_alm_hrs) &
                    (bus.i_cur_min == bus.i_alm_min);
   // Rising edge only: a held alarm minute gives a single event, and leaving
   // setmode on the alarm minute still fires.
   assign w_trig  = w_match & ~r_match_q;
   assign w_off   = ~bus.i_alarmon | bus.i_setmode;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_ring     <= '0;
         r_snz      <= '0;
         r_cnt      <= '0;
         r_buzz     <= 1'b0;
         r_snoozing <= 1'b0;
         r_match_q  <= 1'b0;
      end else begin
         r_match_q <= w_match;
         if (w_off) begin
            r_state    <= IDLE;
            r_ring     <= '0;
            r_snz      <= '0;
            r_buzz     <= 1'b0;
            r_snoozing <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_trig) begin
                     r_state <= RINGING;
                     r_ring  <= '0;
                     r_cnt   <= '0;
                     r_buzz  <= 1'b1;
                  end
               end
               RINGING: begin
                  if (bus.i_dismiss) begin
                     r_state <= IDLE;
                     r_ring  <= '0;
                     r_snz   <= '0;
                     r_buzz  <= 1'b0;
                  end else if (bus.i_snooze && (r_cnt < CW'(MAX_SNOOZE))) begin
                     // Snooze beats a same-cycle ring timeout.
                     r_state    <= SNOOZE;
                     r_cnt      <= r_cnt + CW'(1);
                     r_snz      <= '0;
                     r_buzz     <= 1'b0;
                     r_snoozing <= 1'b1;
                  end else if (bus.i_sec_tick) begin
                     if (r_ring == RW'(RING_SECS - 1)) begin
                        r_state <= IDLE;
                        r_ring  <= '0;
                        r_snz   <= '0;
                        r_buzz  <= 1'b0;
                     end else begin
                        r_ring <= r_ring + RW'(1);
                     end
                  end
               end
               SNOOZE: begin
                  if (bus.i_dismiss) begin
                     r_state    <= IDLE;
                     r_ring     <= '0;
                     r_snz      <= '0;
                     r_snoozing <= 1'b0;
                  end else if (bus.i_sec_tick) begin
                     if (r_snz == SW'(SNOOZE_SECS - 1)) begin
                        r_state    <= RINGING;
                        r_ring     <= '0;
                        r_buzz     <= 1'b1;
                        r_snoozing <= 1'b0;
                     end else begin
                        r_snz <= r_snz + SW'(1);
                     end
                  end
               end
               default: begin
                  r_state    <= IDLE;
                  r_buzz     <= 1'b0;
                  r_snoozing <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.o_buzz       = r_buzz;
   assign bus.o_snoozing   = r_snoozing;
   assign bus.o_snooze_cnt = r_cnt;
endmodule

// File: tb/tb_alarm_sched.sv
module tb_alarm_sched;
   localparam int         RING   = 4;
   localparam int         SNZ    = 3;
   localparam int         MAXS   = 2;
   localparam logic [6:0] MASK   = 7'b0011111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   alarm_sched_if #(.MAX_SNOOZE(MAXS)) bus ();

   alarm_sched #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS),
                 .DAY_MASK(MASK)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // one-clock-wide second tick every two clocks
   initial begin
      bus.i_sec_tick = 1'b0;
      forever begin
         @(negedge clk);
         bus.i_sec_tick = ~bus.i_sec_tick;
      end
   end

   // Reference model: mode 0=idle 1=ring 2=snooze, remaining seconds counted down.
   int m_mode = 0, m_left = 0, m_used = 0;
   bit m_prev = 0;

   function automatic bit ref_match();
      int d;
      d = int'(bus.i_cur_day);
      if (!bus.i_alarmon || bus.i_setmode || d > 6) return 0;
      if (((int'(MASK) >> d) & 1) == 0) return 0;
      return (int'(bus.i_cur_hrs) * 60 + int'(bus.i_cur_min)) ==
             (int'(bus.i_alm_hrs) * 60 + int'(bus.i_alm_min));
   endfunction

   always @(posedge clk or posedge rst) begin
      bit mt, trig;
      if (rst) begin
         m_mode = 0; m_left = 0; m_used = 0; m_prev = 0;
      end else begin
         mt = ref_match();
         trig = mt && !m_prev;
         m_prev = mt;
         if (!bus.i_alarmon || bus.i_setmode) m_mode = 0;
         else if (m_mode != 0 && bus.i_dismiss) m_mode = 0;
         else if (m_mode == 1 && bus.i_snooze && m_used < MAXS) begin
            m_mode = 2; m_used++; m_left = SNZ;
         end else if (m_mode != 0 && bus.i_sec_tick) begin
            m_left--;
            if (m_left == 0) begin
               m_mode = (m_mode == 1) ? 0 : 1;
               if (m_mode == 1) m_left = RING;
            end
         end else if (m_mode == 0 && trig) begin
            m_mode = 1; m_left = RING; m_used = 0;
         end
      end
   end

   task automatic sync();
      @(negedge clk); #1;
   endtask

   task automatic set_time(input int h, input int m, input int d);
      bus.i_cur_hrs = 5'(h); bus.i_cur_min = 6'(m); bus.i_cur_day = 3'(d);
   endtask

   // alarm at 08:01 on day d: step 08:00 -> 08:01
   task automatic fire(input int d);
      set_time(8, 0, d); sync(); sync();
      set_time(8, 1, d); sync();
   endtask

   task automatic pulse_dismiss();
      bus.i_dismiss = 1'b1; sync(); bus.i_dismiss = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (bus.o_buzz !== 1'b0 || bus.o_snoozing !== 1'b0 || bus.o_snooze_cnt !== 2'd0) begin
         bad++; $display("FAIL reset_state: got buzz=%b snz=%b cnt=%0d want 0/0/0",
                         bus.o_buzz, bus.o_snoozing, bus.o_snooze_cnt);
      end
   endtask

   task automatic test_day_gating();
      int days [4] = '{4, 5, 6, 0};
      bit exp  [4] = '{1, 0, 0, 1};
      for (int i = 0; i < 4; i++) begin
         fire(days[i]);
         total++;
         if (bus.o_buzz !== exp[i]) begin
            bad++; $display("FAIL day_gate d=%0d: buzz=%b want %b", days[i], bus.o_buzz, exp[i]);
         end
         pulse_dismiss(); sync();
      end
   endtask

   task automatic test_timeout();
      int ticks = 0, cyc = 0;
      bit stray = 0;
      fire(1);
      total++;
      if (bus.o_buzz !== 1'b1) begin bad++; $display("FAIL timeout_start: buzz=%b want 1", bus.o_buzz); end
      while (bus.o_buzz === 1'b1 && cyc < 100) begin
         if (bus.i_sec_tick) ticks++;
         sync(); cyc++;
      end
      total++;
      if (ticks != RING) begin bad++; $display("FAIL ring_ticks: got %0d want %0d", ticks, RING); end
      for (int i = 0; i < 20; i++) begin sync(); if (bus.o_buzz !== 1'b0) stray = 1; end
      total++;
      if (stray) begin bad++; $display("FAIL no_retrigger: buzz rose again, want 0"); end
      fire(2);
      total++;
      if (bus.o_buzz !== 1'b1) begin bad++; $display("FAIL next_day: buzz=%b want 1", bus.o_buzz); end
      pulse_dismiss();
   endtask

   task automatic test_snooze_limit();
      int ticks = 0, cyc = 0;
      fire(3);
      for (int n = 1; n <= 2; n++) begin
         bus.i_snooze = 1'b1; sync(); bus.i_snooze = 1'b0;
         total++;
         if (bus.o_buzz !== 1'b0 || bus.o_snoozing !== 1'b1 || int'(bus.o_snooze_cnt) != n) begin
            bad++; $display("FAIL snooze%0d: buzz=%b snz=%b cnt=%0d want 0/1/%0d",
                            n, bus.o_buzz, bus.o_snoozing, bus.o_snooze_cnt, n);
         end
         ticks = 0; cyc = 0;
         while (bus.o_snoozing === 1'b1 && cyc < 100) begin
            if (bus.i_sec_tick) ticks++;
            sync(); cyc++;
         end
         total++;
         if (ticks != SNZ || bus.o_buzz !== 1'b1) begin
            bad++; $display("FAIL snooze_wait%0d: ticks=%0d buzz=%b want %0d/1", n, ticks, bus.o_buzz, SNZ);
         end
      end
      // third snooze is over the limit
      ticks = bus.i_sec_tick ? 1 : 0;
      bus.i_snooze = 1'b1; sync(); bus.i_snooze = 1'b0;
      total++;
      if (bus.o_buzz !== 1'b1 || bus.o_snooze_cnt !== 2'd2) begin
         bad++; $display("FAIL snooze_limit: buzz=%b cnt=%0d want 1/2", bus.o_buzz, bus.o_snooze_cnt);
      end
      cyc = 0;
      while (bus.o_buzz === 1'b1 && cyc < 100) begin
         if (bus.i_sec_tick) ticks++;
         sync(); cyc++;
      end
      total++;
      if (ticks != RING) begin bad++; $display("FAIL limit_timeout: ticks=%0d want %0d", ticks, RING); end
   endtask

   task automatic test_priority();
      int cyc = 0;
      bit stray = 0;
      fire(0);
      bus.i_snooze = 1'b1; sync(); bus.i_snooze = 1'b0;
      while (bus.o_buzz !== 1'b1 && cyc < 100) begin sync(); cyc++; end
      bus.i_snooze = 1'b1; bus.i_dismiss = 1'b1; sync();
      bus.i_snooze = 1'b0; bus.i_dismiss = 1'b0;
      total++;
      if (bus.o_buzz !== 1'b0 || bus.o_snoozing !== 1'b0 || bus.o_snooze_cnt !== 2'd1) begin
         bad++; $display("FAIL dismiss_over_snooze: buzz=%b snz=%b cnt=%0d want 0/0/1",
                         bus.o_buzz, bus.o_snoozing, bus.o_snooze_cnt);
      end
      fire(1);
      bus.i_snooze = 1'b1; sync(); bus.i_snooze = 1'b0;
      total++;
      if (bus.o_snoozing !== 1'b1 || bus.o_snooze_cnt !== 2'd1) begin
         bad++; $display("FAIL new_event_cnt: snz=%b cnt=%0d want 1/1", bus.o_snoozing, bus.o_snooze_cnt);
      end
      bus.i_alarmon = 1'b0; sync();
      total++;
      if (bus.o_buzz !== 1'b0 || bus.o_snoozing !== 1'b0) begin
         bad++; $display("FAIL alarm_off: buzz=%b snz=%b want 0/0", bus.o_buzz, bus.o_snoozing);
      end
      set_time(8, 2, 1); sync(); bus.i_alarmon = 1'b1;
      for (int i = 0; i < 20; i++) begin sync(); if (bus.o_buzz !== 1'b0) stray = 1; end
      total++;
      if (stray) begin bad++; $display("FAIL alarm_off_late: buzz rose, want 0"); end
   endtask

   task automatic test_setmode();
      bus.i_setmode = 1'b1;
      set_time(8, 0, 2); sync(); set_time(8, 1, 2);
      sync(); sync(); sync();
      total++;
      if (bus.o_buzz !== 1'b0) begin bad++; $display("FAIL setmode_hold: buzz=%b want 0", bus.o_buzz); end
      bus.i_setmode = 1'b0; sync();
      total++;
      if (bus.o_buzz !== 1'b1) begin bad++; $display("FAIL setmode_release: buzz=%b want 1", bus.o_buzz); end
      pulse_dismiss();
   endtask

   task automatic test_async_reset();
      int cyc = 0;
      fire(3);
      bus.i_snooze = 1'b1; sync(); bus.i_snooze = 1'b0;
      while (bus.o_buzz !== 1'b1 && cyc < 100) begin sync(); cyc++; end
      #1 rst = 1'b1; #1;
      total++;
      if (bus.o_buzz !== 1'b0 || bus.o_snooze_cnt !== 2'd0 || bus.o_snoozing !== 1'b0) begin
         bad++; $display("FAIL async_reset: buzz=%b cnt=%0d snz=%b want 0/0/0",
                         bus.o_buzz, bus.o_snooze_cnt, bus.o_snoozing);
      end
      set_time(8, 0, 3); sync(); sync(); rst = 1'b0;
      sync(); set_time(8, 1, 3); sync();
      total++;
      if (bus.o_buzz !== 1'b1) begin bad++; $display("FAIL post_reset_fire: buzz=%b want 1", bus.o_buzz); end
      pulse_dismiss();
   endtask

   task automatic test_random();
      int errs = 0;
      int am;
      bus.i_alm_hrs = 5'($urandom_range(0, 23));
      am = $urandom_range(1, 58);
      bus.i_alm_min = 6'(am);
      set_time(int'(bus.i_alm_hrs), am - 1, 0);
      sync();
      for (int c = 0; c < 4000; c++) begin
         total++;
         if (bus.o_buzz !== (m_mode == 1) || bus.o_snoozing !== (m_mode == 2) ||
             int'(bus.o_snooze_cnt) != m_used) begin
            errs++; bad++;
            if (errs <= 5)
               $display("FAIL random c=%0d: buzz=%b snz=%b cnt=%0d want %b/%b/%0d", c, bus.o_buzz,
                        bus.o_snoozing, bus.o_snooze_cnt, m_mode == 1, m_mode == 2, m_used);
         end
         bus.i_snooze  = ($urandom % 6) == 0;
         bus.i_dismiss = ($urandom % 60) == 0;
         bus.i_alarmon = ($urandom % 150) != 0;
         bus.i_setmode = ($urandom % 150) == 0;
         if (($urandom % 12) == 0) bus.i_cur_min = 6'(am - 1 + $urandom_range(0, 2));
         if (($urandom % 40) == 0) bus.i_cur_day = 3'($urandom_range(0, 7));
         sync();
      end
      bus.i_snooze = 1'b0; bus.i_dismiss = 1'b0; bus.i_alarmon = 1'b1; bus.i_setmode = 1'b0;
   endtask

   initial begin
      bus.i_alm_hrs = 5'd8; bus.i_alm_min = 6'd1;
      bus.i_alarmon = 1'b1; bus.i_setmode = 1'b0;
      bus.i_snooze = 1'b0; bus.i_dismiss = 1'b0;
      set_time(7, 0, 0);
      sync(); sync();
      test_reset();
      rst = 1'b0;
      sync();
      test_reset();
      test_day_gating();
      test_timeout();
      test_snooze_limit();
      test_priority();
      test_setmode();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alarm_sched.md
Name: alarm_sched

Overview:
- Alarm sequencing controller for the weekday alarm clock datapath.
- Watches current time/day from the time-keeping counters and alarm time from the alarm registers, and owns the Buzz output.
- Adds day-of-week gating, ring timeout, snooze with a retry limit, and dismiss.
- Sits between the clock/alarm counters and the buzzer driver; the display path is untouched.

Parameters:
- RING_SECS, 60: Sec_tick count Buzz stays on per ring before auto-off.
- SNOOZE_SECS, 300: Sec_tick count of silence per snooze.
- MAX_SNOOZE, 3: snoozes honoured per alarm event.
- DAY_MASK, 7'b0011111: bit d=1 enables the alarm on day d (0=Mon..6=Sun); default Mon–Fri.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Sec_tick  in  1  one-Clk-wide pulse once per second.
- Cur_hrs  in  5  current hour, 0–23.
- Cur_min  in  6  current minute, 0–59.
- Cur_day  in  3  current day, 0–6.
- Alm_hrs  in  5  alarm hour.
- Alm_min  in  6  alarm minute.
- Alarmon  in  1  alarm enable level.
- Setmode  in  1  high while Timeset or Alarmset is active.
- Snooze  in  1  one-cycle snooze request.
- Dismiss  in  1  one-cycle dismiss request.
- Buzz  out  1  buzzer drive.
- Snoozing  out  1  high while in snooze wait.
- Snooze_cnt  out  clog2(MAX_SNOOZE+1)  snoozes used in the current event.

Behaviour:
- Reset, asynchronous, any state: state=IDLE; Buzz=0, Snoozing=0, Snooze_cnt=0; ring/snooze timers=0; match_q=0.
- Match logic, combinational:
  - match = Alarmon & ~Setmode & (Cur_hrs==Alm_hrs) & (Cur_min==Alm_min) & DAY_MASK[Cur_day].
  - Cur_day values above 6 give match=0.
  - match_q <= match every cycle, in every state, including during Setmode.
- Trigger = match & ~match_q (rising edge only).
  - A matching minute that is held produces exactly one event.
  - A dismissed or timed-out alarm does not re-fire within the same minute.
  - Releasing Setmode while already on the alarm minute does fire (match rises).
- States: IDLE, RINGING, SNOOZE.
  - IDLE, on Trigger: go to RINGING, clear ring timer, Snooze_cnt=0.
  - RINGING, on Sec_tick: ring timer increments.
  - RINGING, Sec_tick with ring timer==RING_SECS-1: go to IDLE (Buzz held exactly RING_SECS ticks).
  - RINGING, Snooze with Snooze_cnt<MAX_SNOOZE: go to SNOOZE, Snooze_cnt+1, clear snooze timer.
  - RINGING, Snooze with Snooze_cnt==MAX_SNOOZE: ignored, stays RINGING, ring timer unaffected.
  - SNOOZE, on Sec_tick: snooze timer increments.
  - SNOOZE, Sec_tick with snooze timer==SNOOZE_SECS-1: go to RINGING, clear ring timer.
  - RINGING or SNOOZE, on Dismiss: go to IDLE.
  - Any state, Alarmon=0 or Setmode=1: go to IDLE.
- Priority within one cycle: Alarmon=0/Setmode > Dismiss > Snooze > timer expiry > Trigger.
- Snooze and a timeout in the same cycle: snooze wins (when still allowed).
- Outputs are registered:
  - Buzz = (state==RINGING).
  - Snoozing = (state==SNOOZE).
  - Both change on the Clk edge that changes state, so Buzz rises on the edge after the cycle in which Trigger is seen.
- Snooze_cnt holds its value in IDLE until the next Trigger; it resets only on Trigger or Reset.
- A snooze wait crossing the alarm minute boundary, or a day change, does not cancel the event.
- Entering IDLE clears both timers.

Test Plan (sim params RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2, Sec_tick every 2 Clk):
- Day gating: alarm 08:01; time steps to 08:01 on day 4 -> Buzz=1 one edge later. Repeat on day 5 and day 6 -> Buzz stays 0. Repeat on day 0 -> Buzz=1.
- Timeout/no retrigger: after trigger with no input, Buzz=1 for exactly 4 Sec_ticks, then 0. Cur_min remains 01 -> Buzz stays 0 until the next day's 08:01.
- Snooze limit:
  - Snooze while ringing -> Buzz=0, Snoozing=1, Snooze_cnt=1; after 3 ticks Buzz=1.
  - Second Snooze -> Snooze_cnt=2.
  - Third Snooze -> ignored, Buzz stays 1, times out after 4 ticks.
- Priority: Snooze and Dismiss in the same cycle -> IDLE, Buzz=0, Snooze_cnt unchanged. Alarmon dropped during SNOOZE -> IDLE next edge, no later Buzz.
- Setmode: set time to 08:01 with Setmode=1 -> Buzz=0; Setmode released at 08:01 -> Buzz=1 next edge.
- Async reset while RINGING: Reset asserted between clock edges -> Buzz=0, Snooze_cnt=0 immediately. Re-entering 08:01 after Reset deasserts triggers normally.
